// File: rtl/i2s_tx_pkg.sv
// Shared constants and types for the I2S transmitter: frame geometry,
// word-select encoding and the slot counter type.
package i2s_tx_pkg;

  localparam int unsigned SAMPLE_W        = 16;
  localparam int unsigned SLOTS_PER_FRAME = 32;
  localparam int unsigned SLOT_W          = $clog2(SLOTS_PER_FRAME);
  // Last slot that carries left-channel data (left[0]).
  localparam int unsigned LEFT_LAST_SLOT  = 16;

  typedef enum logic {
    LR_LEFT  = 1'b0,
    LR_RIGHT = 1'b1
  } lr_e;

  typedef logic [SLOT_W-1:0] slot_t;

  function automatic slot_t slot_inc(input slot_t s);
    return (s == slot_t'(SLOTS_PER_FRAME - 1)) ? '0 : s + slot_t'(1);
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider and slot counter. slot_start marks the edge on which
// bclk falls, which is also the edge that advances the slot index.
module i2s_bclk_gen
  import i2s_tx_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic              bclk,
  output logic              slot_start,
  output logic [SLOT_W-1:0] slot
);

  logic [7:0] div_cnt_q, div_cnt_d;
  logic       bclk_q, bclk_d;
  slot_t      slot_q, slot_d;
  logic       tick;

  assign tick       = (div_cnt_q == 8'(BCLK_DIV - 1));
  assign slot_start = en & tick & bclk_q;

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + 8'd1;
    bclk_d    = tick ? ~bclk_q : bclk_q;
    slot_d    = slot_start ? slot_inc(slot_q) : slot_q;
    if (!en) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
      slot_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      slot_q    <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      slot_q    <= slot_d;
    end
  end

  assign bclk = bclk_q;
  assign slot = slot_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: latches {left,right} once per frame on entry to slot 1,
// shifts it out MSB first with the standard one-bclk delay after lrclk.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 4,
  parameter int unsigned WIDTH    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             sample
);

  logic              slot_start;
  logic [SLOT_W-1:0] slot;
  slot_t             next_slot;

  logic [2*WIDTH-1:0] shreg_q, shreg_d;
  logic               sdata_q, sdata_d;
  logic               sample_q, sample_d;
  lr_e                lr_q, lr_d;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .bclk       (bclk),
    .slot_start (slot_start),
    .slot       (slot)
  );

  assign next_slot = slot_inc(slot);

  // Word select leads the data by one slot, so it switches on entry to the
  // slot after LEFT_LAST_SLOT-1; the MSB leaves on entry to slot 1.
  always_comb begin
    shreg_d  = shreg_q;
    sdata_d  = sdata_q;
    lr_d     = lr_q;
    sample_d = 1'b0;
    if (!en) begin
      shreg_d = '0;
      sdata_d = 1'b0;
      lr_d    = LR_LEFT;
    end else if (slot_start) begin
      lr_d = (next_slot >= slot_t'(LEFT_LAST_SLOT)) ? LR_RIGHT : LR_LEFT;
      if (next_slot == slot_t'(1)) begin
        shreg_d  = {left, right};
        sdata_d  = left[WIDTH-1];
        sample_d = 1'b1;
      end else begin
        sdata_d = shreg_q[2*WIDTH-2];
        shreg_d = {shreg_q[2*WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q  <= '0;
      sdata_q  <= 1'b0;
      sample_q <= 1'b0;
      lr_q     <= LR_LEFT;
    end else begin
      shreg_q  <= shreg_d;
      sdata_q  <= sdata_d;
      sample_q <= sample_d;
      lr_q     <= lr_d;
    end
  end

  assign lrclk  = lr_q;
  assign sdata  = sdata_q;
  assign sample = sample_q;

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Serializes the two 16-bit filtered channel outputs (left, right) onto a standard I2S link driving the board DAC.
- Generates the bit clock (bclk), word select (lrclk) and serial data (sdata) from the system clock.
- Issues the one-cycle `sample` strobe once per frame. This strobe paces the upstream FIR channels.
- Forms the output end of the sample path; it is the counterpart of the sample-strobed filter input.

Parameters:
- BCLK_DIV, 4, system clk cycles per bclk half-period; legal range 1..255.
- WIDTH, 16, bits per channel word; fixed at 16 for this design.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  link enable; low forces idle.
- left  in  16  left-channel sample, two's complement. Sampled only at the frame latch edge.
- right  in  16  right-channel sample, two's complement. Sampled only at the frame latch edge.
- bclk  out  1  I2S bit clock, registered.
- lrclk  out  1  word select: 0 = left, 1 = right. Registered.
- sdata  out  1  serial data, MSB first. Registered.
- sample  out  1  one-clk pulse per frame at the latch edge. Drives the FIR `sample` input.

Behaviour:
- Reset (sync, active-high, also whenever en=0):
  - bclk=0, lrclk=0, sdata=0, sample=0.
  - div_cnt=0, slot=0, shift register=0.
  - Reset mid-frame abandons the frame immediately; no partial words carry over.
- Timing base:
  - div_cnt counts 0..BCLK_DIV-1. bclk toggles on the edge where div_cnt wraps.
  - One bit slot = 2*BCLK_DIV clk cycles. Frame = 32 slots (0..31) = 64*BCLK_DIV clk.
  - The first clk after reset/en release is the first cycle of slot 0, with bclk low.
- Slot boundary:
  - Occurs on the same edge that drives bclk 1->0.
  - lrclk, sdata and the slot counter update only on slot boundaries. The DAC samples on bclk rising, mid-slot.
  - slot wraps 31->0.
- lrclk: 0 during slots 0..15, 1 during slots 16..31.
- Frame latch, on the edge entering slot 1:
  - Shift register <= {left, right} (32 bits).
  - sdata <= left[15].
  - sample <= 1 for exactly one clk, cleared on the next edge.
- Bit mapping (standard I2S one-bclk delay after the lrclk change):
  - slot s in 1..31 carries frame bit 31-(s-1): slots 1..16 carry left[15:0], slots 17..31 carry right[15:1].
  - Slot 0 of the following frame carries right[0].
  - Slot 0 of the first frame after reset carries 0.
- Latency: left/right present at the latch edge appear on sdata starting at that edge. The LSB leaves 32 slots later.
- Input handling:
  - Inputs are not double-buffered; changes between latch edges are ignored.
  - Upstream must hold stable values at the latch edge. FIR registered outputs satisfy this because frame length ≥ 64 clk > 34-cycle FIR MAC.
- en:
  - en 1->0 takes effect on the next edge: same as reset, outputs idle.
  - en 0->1: the next edge starts slot 0 cycle 0, identical to post-reset.
- Simultaneous reset and en: reset dominates.
- No saturation or arithmetic; data bits pass through unchanged.

Decomposition:
- Shared package: SAMPLE_W=16, SLOTS_PER_FRAME=32, LEFT_LAST_SLOT=16 (last slot carrying left[0]); lrclk encoding constants LR_LEFT=0, LR_RIGHT=1.
- Sub-module i2s_bclk_gen:
  - Divider plus slot counter.
  - Outputs bclk, a slot-boundary pulse, and the current slot index.
- i2s_tx holds the shift register, lrclk/sdata/sample registers and enable gating.

Test Plan:
- Reset release, BCLK_DIV=2, en=1 -> first bclk rise at clk 2; bclk period 4 clk; lrclk=0 for clk 0..63, 1 for clk 64..127; sample high only at clk 4 (slot 1 entry), then every 128 clk.
- left=16'hA5C3, right=16'h0F01 held -> sdata over slots 1..31 = 1010010111000011 000011110000000; slot 0 of next frame = 1; capture on bclk rise matches.
- Change left to 16'h7FFF mid-frame (slot 10), back to 16'hA5C3 before the next latch -> current and next frame both show A5C3; 7FFF never appears.
- Assert reset at slot 20 -> next cycle bclk=lrclk=sdata=sample=0; after release, timing restarts exactly as in scenario 1.
- en=0 for 50 clk mid-frame, then en=1 -> outputs idle throughout; sample pulse 4 clk after the re-enable edge; first word = inputs at that edge.
- BCLK_DIV=1, left=16'h8000, right=16'h0001 -> bclk toggles every clk; frame = 64 clk; sample period 64; sdata=1 only in slot 1 and in slot 0 of the next frame.
